// File: rtl/gsm_pkg.sv
// Shared types and default sizing for the GSM TDM FIR sequencer.
package gsm_pkg;

    // Default time-share configuration: 4 phases, 2-bit index, 2-cycle product pipe.
    localparam int NUM_PHASES_DEF = 4;
    localparam int PH_W_DEF       = 2;
    localparam int PIPE_LAT_DEF   = 2;

    // Drain counter covers PIPE_LAT up to 7.
    localparam int DRAIN_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } coef_bank_t;

endpackage

// File: rtl/gsm_seq_dly.sv
// Delay line that re-times phase issue to the accumulator input.
// Each stage carries the issue-valid bit and whether the issued phase was 0,
// which is all the accumulator needs to know about the delayed phase.
module gsm_seq_dly #(
    parameter int PH_W     = 2,
    parameter int PIPE_LAT = 2
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic            vld_i,
    input  logic [PH_W-1:0] phase_i,
    output logic            acc_en_o,
    output logic            acc_clr_o
);

    logic [PIPE_LAT-1:0] vld_q;
    logic [PIPE_LAT-1:0] first_q;

    // Shift register; reset flushes in-flight phases so an aborted pass leaves no trace.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            vld_q   <= '0;
            first_q <= '0;
        end else begin
            vld_q[0]   <= vld_i;
            first_q[0] <= vld_i && (phase_i == '0);
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
            end
        end
    end

    assign acc_en_o  = vld_q[PIPE_LAT-1];
    assign acc_clr_o = first_q[PIPE_LAT-1];

endmodule

// File: rtl/gsm_tdm_sequencer.sv
// Phase sequencer for the time-shared symmetric FIR: one pass of phase
// indices per sample strobe, aligned accumulator control, overrun flag and
// coefficient-bank handshake. Optional macro SEQ_OVR_CNT_EN adds a
// saturating dropped-strobe counter on port ovr_cnt.
module gsm_tdm_sequencer
    import gsm_pkg::*;
#(
    parameter int NUM_PHASES = NUM_PHASES_DEF,
    parameter int PH_W       = PH_W_DEF,
    parameter int PIPE_LAT   = PIPE_LAT_DEF
) (
    input  logic            sys_clk,
    input  logic            reset,
    input  logic            sam_clk_en,
    output logic [PH_W-1:0] phase,
    output logic            phase_vld,
    output logic            acc_clr,
    output logic            acc_en,
    output logic            y_load,
    output logic            busy,
    output logic            overrun,
    input  logic            ovr_clr,
    input  logic            bank_req,
    output logic            bank_ack,
`ifdef SEQ_OVR_CNT_EN
    output logic [7:0]      ovr_cnt,
`endif
    output logic            bank_sel
);

    localparam logic [PH_W-1:0]    LAST_PH   = PH_W'(NUM_PHASES - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRN  = DRAIN_W'(PIPE_LAT - 1);

    seq_state_t         state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               phase_vld_q, phase_vld_d;
    logic               busy_q, busy_d;
    logic               y_load_q, y_load_d;
    logic               overrun_q, overrun_d;
    logic               bank_ack_q, bank_ack_d;
    logic               armed_q, armed_d;
    coef_bank_t         bank_q, bank_d;
    logic               drop;
    logic               swap;

    // A strobe while a pass is running is dropped; swaps only happen in a quiet IDLE cycle.
    assign drop = sam_clk_en && (state_q != ST_IDLE);
    assign swap = (state_q == ST_IDLE) && bank_req && armed_q && !sam_clk_en;

    // State register.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> RUN on strobe, RUN -> DRAIN after last phase, DRAIN -> IDLE after PIPE_LAT cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (sam_clk_en) state_d = ST_RUN;
            ST_RUN:   if (phase_q == LAST_PH) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_q == LAST_DRN) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the bookkeeping counters.
    always_comb begin
        phase_d     = phase_q;
        phase_vld_d = 1'b0;
        drain_d     = drain_q;
        busy_d      = (state_d != ST_IDLE);
        y_load_d    = (state_q == ST_DRAIN) && (state_d == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (sam_clk_en) begin
                    phase_d     = '0;
                    phase_vld_d = 1'b1;
                end
            end
            ST_RUN: begin
                drain_d = '0;
                if (phase_q != LAST_PH) begin
                    phase_d     = phase_q + 1'b1;
                    phase_vld_d = 1'b1;
                end
            end
            ST_DRAIN: drain_d = drain_q + 1'b1;
            default: ;
        endcase

        overrun_d  = drop ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);
        bank_ack_d = swap;
        bank_d     = bank_q;
        armed_d    = armed_q;
        if (swap) begin
            bank_d  = (bank_q == BANK_0) ? BANK_1 : BANK_0;
            armed_d = 1'b0;
        end else if (!bank_req) begin
            armed_d = 1'b1;
        end
    end

    // Output and bookkeeping registers; armed comes out of reset ready for one swap.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            phase_q     <= '0;
            phase_vld_q <= 1'b0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            y_load_q    <= 1'b0;
            overrun_q   <= 1'b0;
            bank_ack_q  <= 1'b0;
            bank_q      <= BANK_0;
            armed_q     <= 1'b1;
        end else begin
            phase_q     <= phase_d;
            phase_vld_q <= phase_vld_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            y_load_q    <= y_load_d;
            overrun_q   <= overrun_d;
            bank_ack_q  <= bank_ack_d;
            bank_q      <= bank_d;
            armed_q     <= armed_d;
        end
    end

`ifdef SEQ_OVR_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    // Saturating count of dropped strobes; a clear beats an increment.
    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (ovr_clr) begin
            ovr_cnt_d = '0;
        end else if (drop && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    // Dropped-strobe counter register.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            ovr_cnt_q <= '0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign ovr_cnt = ovr_cnt_q;
`endif

    gsm_seq_dly #(
        .PH_W     (PH_W),
        .PIPE_LAT (PIPE_LAT)
    ) u_dly (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .vld_i     (phase_vld_q),
        .phase_i   (phase_q),
        .acc_en_o  (acc_en),
        .acc_clr_o (acc_clr)
    );

    assign phase     = phase_q;
    assign phase_vld = phase_vld_q;
    assign busy      = busy_q;
    assign y_load    = y_load_q;
    assign overrun   = overrun_q;
    assign bank_ack  = bank_ack_q;
    assign bank_sel  = bank_q;

endmodule

// File: doc/gsm_tdm_sequencer.md
Name: gsm_tdm_sequencer

Overview:
- Control block for the time-shared symmetric FIR datapath: 13 physical multipliers serve 51 folded taps over 4 phases per output sample.
- Turns each sam_clk_en strobe into one pass of phase indices, with pipeline-aligned accumulator clear/enable and an output-load strobe.
- Detects strobes that arrive too fast (overrun).
- Owns the coefficient-bank select and its handshake, so filter coefficients change only between passes.

Parameters:
- NUM_PHASES, 4, phases per output sample (multiplier time-share factor).
- PH_W, 2, width of the phase index; must satisfy 2**PH_W >= NUM_PHASES.
- PIPE_LAT, 2, sys_clk cycles from phase issue to the product being valid at the accumulator input; legal range 1..7.

Ports:
- sys_clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sam_clk_en  in  1  sample strobe, one sys_clk cycle wide; starts a pass
- phase  out  PH_W  mux select for the multiplier input and coefficient muxes
- phase_vld  out  1  phase is being issued this cycle
- acc_clr  out  1  accumulator loads the product instead of adding it
- acc_en  out  1  accumulator captures this cycle
- y_load  out  1  one-cycle pulse: accumulator result is final, register it to y
- busy  out  1  a pass is in progress (state != IDLE)
- overrun  out  1  sticky: a sam_clk_en was dropped
- ovr_clr  in  1  clears overrun
- bank_req  in  1  request to toggle the coefficient bank
- bank_ack  out  1  one-cycle pulse: toggle done
- bank_sel  out  1  active coefficient bank

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0 on the next edge, including phase, bank_sel and overrun. The delay pipeline is flushed, so a pass interrupted by reset never produces acc_en or y_load afterwards.
- FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN: sam_clk_en=1 at cycle t.
- RUN, cycles t+1..t+NUM_PHASES: phase=0,1,..,NUM_PHASES-1; phase_vld=1. Leaves for DRAIN after the last phase.
- DRAIN, PIPE_LAT cycles: phase_vld=0; phase holds its last value; then -> IDLE.
- acc_en = phase_vld delayed PIPE_LAT cycles.
- acc_clr = acc_en AND (delayed phase == 0).
- y_load = 1 for one cycle after the final acc_en, i.e. at cycle t+NUM_PHASES+PIPE_LAT+1. This is the same cycle the FSM is back in IDLE.
- Latency from strobe to y_load is NUM_PHASES+PIPE_LAT+1 cycles (7 with defaults). This is also the minimum accepted strobe spacing.
- A sam_clk_en arriving in the same cycle as y_load is accepted, so back-to-back passes are legal.
- Overrun: sam_clk_en while busy=1 is ignored (the current pass is unaffected) and overrun is set on the next edge.
  - overrun stays set until ovr_clr or reset.
  - If ovr_clr and a new overrun occur in the same cycle, the set wins.
- Bank swap:
  - Condition: state=IDLE, bank_req=1, armed=1, and sam_clk_en=0 this cycle.
  - Result on the next edge: bank_sel toggles, bank_ack=1 for one cycle, armed=0.
  - armed returns to 1 only after bank_req has been sampled 0, so a request held high toggles the bank exactly once.
  - If sam_clk_en and a swap request coincide, the pass starts first on the old bank; the swap happens on the first eligible IDLE cycle after the pass.
  - bank_sel never changes while busy=1.
- All outputs are registered. No combinational path from any input to any output.

Optional Feature:
- Macro: SEQ_OVR_CNT_EN.
- When defined: adds output ovr_cnt[7:0], a count of dropped strobes that saturates at 255. It is cleared by reset or ovr_clr; ovr_clr takes priority over the increment in the same cycle. The overrun flag still behaves as specified above.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package gsm_pkg holds:
  - the state enum (IDLE/RUN/DRAIN);
  - NUM_PHASES, PH_W and PIPE_LAT defaults;
  - the coefficient bank type.
- One natural sub-module, gsm_seq_dly: a parameterised delay line of PIPE_LAT stages carrying {phase_vld, phase}, with synchronous reset. It produces acc_en and acc_clr.

Test Plan:
- Single pass:
  - Stimulus: reset, then sam_clk_en at cycle 10.
  - Expected: phase 0,1,2,3 with phase_vld=1 on cycles 11-14; acc_en on 13-16 with acc_clr only on 13; y_load on cycle 17; busy on 11-16.
- Back-to-back:
  - Stimulus: strobes at cycles 10, 17, 24.
  - Expected: three clean passes, y_load at 17, 24 and 31; overrun stays 0.
- Overrun:
  - Stimulus: strobes at 10 and 14.
  - Expected: the second strobe is dropped and overrun=1 from cycle 15; the first pass is unchanged with y_load at 17.
  - Then ovr_clr at 20: overrun=0 at 21.
  - With SEQ_OVR_CNT_EN: ovr_cnt=1 at 15 and 0 at 21.
- Bank handshake:
  - Stimulus: bank_req raised at 12 (mid-pass) and held high.
  - Expected: bank_sel toggles and bank_ack pulses at cycle 18; no second toggle while bank_req stays high.
  - Then drop bank_req, re-raise it at 30: second toggle at 31.
- Reset mid-pass:
  - Stimulus: strobe at 10, reset at 13.
  - Expected: from cycle 14, every output is 0 and no acc_en or y_load appears.
  - A strobe at 16 then runs a normal pass with y_load at 23.
- Coincident strobe and swap:
  - Stimulus: sam_clk_en and bank_req both high at cycle 10.
  - Expected: the pass runs on the old bank; bank_ack at 18.
